pit_multi: RTL and testbench



---
 rtl/pit_multi.sv | 129 ++++++++++++
 tb/tb_pit_multi.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pit_multi.sv
// Multi-channel interval timer: CHANNELS down-counters sharing one prescaler, with expiry pulses.
// Optional sticky pending flags are built when PIT_MULTI_PENDING_EN is defined.
module pit_multi #(
   parameter int CHANNELS       = 4,
   parameter int WIDTH          = 16,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          enable,
   input  logic [PRESCALE_WIDTH-1:0]                     prescale,
   input  logic                                          cfg_valid,
   input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] cfg_chan,
   input  logic [WIDTH-1:0]                              cfg_reload,
   input  logic                                          cfg_repeating,
   input  logic                                          cfg_start,
   input  logic [CHANNELS-1:0]                           irq_clear,
   output logic [CHANNELS-1:0]                           interrupting,
   output logic [CHANNELS-1:0]                           irq_pending,
   output logic                                          irq_any
);

   localparam int CW = $clog2(CHANNELS > 1 ? CHANNELS : 2);

   typedef enum logic {IDLE, RUN} state_t;

   logic [PRESCALE_WIDTH-1:0] pcnt;
   logic                      tick;

   state_t             state_q  [CHANNELS];
   state_t             state_d  [CHANNELS];
   logic [WIDTH-1:0]   count_q  [CHANNELS];
   logic [WIDTH-1:0]   count_d  [CHANNELS];
   logic [WIDTH-1:0]   reload_q [CHANNELS];
   logic [WIDTH-1:0]   reload_d [CHANNELS];
   logic [CHANNELS-1:0] rep_q;
   logic [CHANNELS-1:0] rep_d;
   logic [CHANNELS-1:0] fire;

   assign tick = enable && (pcnt == prescale);

   // The prescaler phase is shared and never restarted by config writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt <= '0;
      end else if (enable) begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i]  <= IDLE;
            count_q[i]  <= '0;
            reload_q[i] <= '0;
         end
         rep_q        <= '0;
         interrupting <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i]  <= state_d[i];
            count_q[i]  <= count_d[i];
            reload_q[i] <= reload_d[i];
         end
         rep_q        <= rep_d;
         interrupting <= fire;
      end
   end

   // A config write to a channel swallows that channel's tick in the same cycle.
   always_comb begin
      fire  = '0;
      rep_d = rep_q;
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i]  = state_q[i];
         count_d[i]  = count_q[i];
         reload_d[i] = reload_q[i];
         if (cfg_valid && (cfg_chan == CW'(i))) begin
            if (!cfg_start) begin
               state_d[i] = IDLE;
            end else if (cfg_reload != '0) begin
               state_d[i]  = RUN;
               count_d[i]  = cfg_reload;
               reload_d[i] = cfg_reload;
               rep_d[i]    = cfg_repeating;
            end else begin
               state_d[i] = IDLE;
               count_d[i] = '0;
            end
         end else if (state_q[i] == RUN && tick) begin
            if (count_q[i] == WIDTH'(1)) begin
               fire[i] = 1'b1;
               if (rep_q[i]) begin
                  count_d[i] = reload_q[i];
               end else begin
                  count_d[i] = '0;
                  state_d[i] = IDLE;
               end
            end else begin
               count_d[i] = count_q[i] - 1'b1;
            end
         end
      end
   end

`ifdef PIT_MULTI_PENDING_EN
   logic [CHANNELS-1:0] pending_q;

   // A fire in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= (pending_q & ~irq_clear) | fire;
      end
   end

   assign irq_pending = pending_q;
   assign irq_any     = |pending_q;
`else
   logic clear_unused;

   assign clear_unused = ^irq_clear;
   assign irq_pending  = '0;
   assign irq_any      = |interrupting;
`endif

endmodule

// File: tb/tb_pit_multi.sv
// Directed bench for pit_multi: a per-cycle vector table plus interval-measuring sequences.
module tb_pit_multi;

`ifdef PIT_MULTI_PENDING_EN
   localparam bit PEND = 1'b1;
`else
   localparam bit PEND = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [7:0]  prescale;
   logic        cfg_valid;
   logic [1:0]  cfg_chan;
   logic [15:0] cfg_reload;
   logic        cfg_repeating;
   logic        cfg_start;
   logic [2:0]  irq_clear;
   logic [2:0]  interrupting;
   logic [2:0]  irq_pending;
   logic        irq_any;

   int total  = 0;
   int passed = 0;
   logic [2:0] seen;

   always #5 clk = ~clk;

   pit_multi #(.CHANNELS(3), .WIDTH(16), .PRESCALE_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .enable(enable), .prescale(prescale),
      .cfg_valid(cfg_valid), .cfg_chan(cfg_chan), .cfg_reload(cfg_reload),
      .cfg_repeating(cfg_repeating), .cfg_start(cfg_start), .irq_clear(irq_clear),
      .interrupting(interrupting), .irq_pending(irq_pending), .irq_any(irq_any)
   );

   typedef struct {
      logic        r;
      logic        en;
      logic [7:0]  pre;
      logic        cv;
      logic [1:0]  ch;
      logic [15:0] rl;
      logic        rep;
      logic        st;
      logic [2:0]  clr;
      logic [2:0]  e_int;
      logic [2:0]  e_pend;
   } vec_t;

   vec_t tbl[25];

   function automatic vec_t mk(bit r, bit en, int pre, bit cv, int ch, int rl, bit rep,
                               bit st, int clr, int e_int, int e_pend);
      vec_t v;
      v.r = r; v.en = en; v.pre = 8'(pre); v.cv = cv; v.ch = 2'(ch); v.rl = 16'(rl);
      v.rep = rep; v.st = st; v.clr = 3'(clr); v.e_int = 3'(e_int); v.e_pend = 3'(e_pend);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int pre);
      rst = 1'b1; enable = 1'b1; prescale = 8'(pre); cfg_valid = 1'b0;
      cfg_chan = '0; cfg_reload = '0; cfg_repeating = 1'b0; cfg_start = 1'b0; irq_clear = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic write(input int ch, input int rl, input bit rep, input bit st);
      cfg_valid = 1'b1; cfg_chan = 2'(ch); cfg_reload = 16'(rl);
      cfg_repeating = rep; cfg_start = st;
      step();
      cfg_valid = 1'b0;
   endtask

   // Returns the number of edges until interrupting[ch] is seen, or -1 on timeout.
   task automatic wait_pulse(input int ch, input int limit, output int n);
      n = -1;
      seen = '0;
      for (int c = 1; c <= limit; c++) begin
         step();
         seen |= interrupting;
         if (interrupting[ch]) begin
            n = c;
            break;
         end
      end
   endtask

   initial begin
      int n;
      string nm;

      // One-shot with prescale 3, pending clear, set+clear collision, reset mid-run.
      tbl[0]  = mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 1, 3, 1, 1, 3, 0, 1, 0, 0, 0);
      for (int i = 2; i <= 11; i++) tbl[i] = mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[12] = mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010);
      tbl[13] = mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3'b010);
      tbl[14] = mk(0, 1, 3, 0, 0, 0, 0, 0, 3'b010, 0, 0);
      tbl[15] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(0, 1, 0, 1, 1, 2, 0, 1, 0, 0, 0);
      tbl[17] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[18] = mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b010, 3'b010, 3'b010);
      tbl[19] = mk(0, 1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0);
      tbl[20] = mk(0, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0);
      tbl[21] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[22] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b001);
      tbl[23] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[24] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 25; i++) begin
         rst = tbl[i].r; enable = tbl[i].en; prescale = tbl[i].pre;
         cfg_valid = tbl[i].cv; cfg_chan = tbl[i].ch; cfg_reload = tbl[i].rl;
         cfg_repeating = tbl[i].rep; cfg_start = tbl[i].st; irq_clear = tbl[i].clr;
         step();
         nm = $sformatf("vec%0d_int", i);
         chk(nm, int'(interrupting), int'(tbl[i].e_int));
         nm = $sformatf("vec%0d_pend", i);
         chk(nm, int'(irq_pending), PEND ? int'(tbl[i].e_pend) : 0);
         nm = $sformatf("vec%0d_any", i);
         chk(nm, int'(irq_any), PEND ? int'(|tbl[i].e_pend) : int'(|tbl[i].e_int));
      end

      // ch0 repeating 10: first pulse 10 edges after the write, one-cycle wide, period 10.
      do_reset(0);
      write(0, 10, 1'b1, 1'b1);
      wait_pulse(0, 40, n);
      chk("rep10_first", n, 10);
      chk("rep10_others", int'(seen & 3'b110), 0);
      step();
      chk("rep10_width", int'(interrupting[0]), 0);
      wait_pulse(0, 40, n);
      chk("rep10_period", n, 9);
      chk("rep10_others2", int'(seen & 3'b110), 0);

      // ch2 repeating 5 with a 7-cycle enable gap: stretched interval of 12, then 5 again.
      do_reset(0);
      write(2, 5, 1'b1, 1'b1);
      wait_pulse(2, 20, n);
      chk("rep5_first", n, 5);
      n = -1;
      for (int c = 1; c <= 30; c++) begin
         enable = !(c >= 3 && c <= 9);
         step();
         if (interrupting[2]) begin
            n = c;
            break;
         end
      end
      enable = 1'b1;
      chk("rep5_stretched", n, 12);
      wait_pulse(2, 20, n);
      chk("rep5_after", n, 5);

      // Zero-reload start and out-of-range channel leave ch0 undisturbed; rewrite restarts.
      do_reset(0);
      write(0, 10, 1'b1, 1'b1);
      write(3, 2, 1'b1, 1'b1);
      write(1, 0, 1'b1, 1'b1);
      wait_pulse(0, 40, n);
      chk("ignored_writes_ch0", n, 8);
      chk("ignored_writes_seen", int'(seen), 1);
      wait_pulse(0, 5, n);
      chk("restart_gap", n, -1);
      write(0, 10, 1'b1, 1'b1);
      wait_pulse(0, 40, n);
      chk("restart_full", n, 10);
      write(0, 10, 1'b1, 1'b0);
      wait_pulse(0, 25, n);
      chk("stop_no_pulse", n, -1);
      chk("stop_seen", int'(seen), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
